serial_fa_adder: RTL and testbench
==================================

Name: serial_fa_adder

Overview:
- Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop.
- Successor to the combinational 1-bit FA: it processes WIDTH-bit operands LSB-first, one bit per clock.
- Uses a start/busy/done handshake so a controller or testbench can issue back-to-back operations.
- Trades latency (WIDTH cycles) for a single adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- iStart  input  1  request a new operation; sampled only in IDLE or DONE
- iSub  input  1  0 = add, 1 = subtract; latched at accepted start
- iA  input  WIDTH  operand A; latched at accepted start
- iB  input  WIDTH  operand B; latched at accepted start
- iC  input  1  carry-in for add; ignored when iSub=1
- oS  output  WIDTH  last completed result
- oC  output  1  final carry-out of last operation (sub: 1 = no borrow)
- oOvf  output  1  signed overflow of last operation
- oBusy  output  1  high while bits are being processed
- oDone  output  1  one-cycle pulse when the result is updated

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - State goes to IDLE.
  - Internal shift registers, bit counter and carry FF are cleared.
  - oS=0, oC=0, oOvf=0, oBusy=0, oDone=0.
  - A partial operation is discarded; no oDone is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - If iStart=1 at a rising edge, the start is accepted. Load A_sh<=iA, B_sh<=(iSub ? ~iB : iB), carry<=(iSub ? 1 : iC), count<=0, and go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Compute the FA of {A_sh[0], B_sh[0], carry}.
  - Shift the sum bit into the MSB of the partial register R_sh; shift A_sh and B_sh right by one.
  - carry<=cout; count<=count+1.
  - On the edge where count==WIDTH-1:
    - oS<=final R_sh, which includes this bit.
    - oC<=cout.
    - oOvf<=carry_in_to_MSB XOR cout, where carry_in_to_MSB is the carry FF value at that edge.
    - Go to DONE.
  - iStart is ignored in RUN; nothing is queued.
- DONE:
  - oDone=1 for exactly this one cycle.
  - If iStart=1 at the next edge, accept the new operation (same load as IDLE) and go to RUN. Otherwise go to IDLE.
- Outputs:
  - oBusy=1 exactly while in RUN.
  - oDone=1 exactly while in DONE.
  - Both are registered state decodes, with no combinational path from iStart.
- Latency: start accepted at edge k gives oBusy high for cycles k+1..k+WIDTH; oS/oC/oOvf update and oDone rises after edge k+WIDTH.
- Throughput: one op per WIDTH+1 cycles when iStart is held high.
- Result hold: oS/oC/oOvf hold their values until the next completion or reset; they never show partial sums.
- Operand changes on iA/iB/iSub/iC after the accepting edge have no effect on the running operation.
- Arithmetic: the result is modulo 2^WIDTH.
  - Add: {oC,oS} = iA+iB+iC.
  - Sub: oS = iA-iB; oC = (iA>=iB unsigned).
  - oOvf follows two's-complement rules.
- WIDTH=1: RUN lasts one cycle; the MSB carry-in is the initial carry.
- count width = clog2(WIDTH) (min 1); no wrap beyond WIDTH-1.

Test Plan:
- Add (WIDTH=8): iA=0x5A, iB=0x3C, iC=0, pulse iStart -> oBusy high 8 cycles; oDone 1 cycle after the 8th; oS=0x96, oC=0, oOvf=1.
- Add with carry-in: iA=0xFF, iB=0x01, iC=1 -> oS=0x01, oC=1, oOvf=0. Then iA=0x00, iB=0x00, iC=0 -> oS=0x00, oC=0, oOvf=0.
- Subtract: iSub=1, iA=0x10, iB=0x20 -> oS=0xF0, oC=0, oOvf=0. Then iA=0x80, iB=0x01 -> oS=0x7F, oC=1, oOvf=1.
- Handshake:
  - Hold iStart=1 continuously with changing operands -> a new op is accepted only in DONE, and oDone pulses every 9 cycles.
  - An iStart pulse and operand changes mid-RUN -> ignored; the result matches the originally latched operands.
- Reset: assert rst asynchronously at bit 4 of an operation -> outputs go to 0 immediately, with no oDone. After release, a fresh op 0x01+0x01 -> oS=0x02.
- Exhaustive WIDTH=3 instance: all 2x8x8x2 (iSub,iA,iB,iC) combinations -> oS/oC/oOvf match the reference model, and latency is 3 cycles each.

Source files
------------

// File: rtl/serial_fa_adder_if.sv
// serial_fa_adder_if
//   Start/busy/done handshake and operand/result bundle for serial_fa_adder.
//   master : drives iStart, iSub, iA, iB, iC; observes oS, oC, oOvf, oBusy, oDone
//   slave  : the adder side of the same signals
interface serial_fa_adder_if #(
  parameter int WIDTH = 8
);
  logic             iStart;
  logic             iSub;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iC;
  logic [WIDTH-1:0] oS;
  logic             oC;
  logic             oOvf;
  logic             oBusy;
  logic             oDone;

  modport master (
    output iStart, iSub, iA, iB, iC,
    input  oS, oC, oOvf, oBusy, oDone
  );

  modport slave (
    input  iStart, iSub, iA, iB, iC,
    output oS, oC, oOvf, oBusy, oDone
  );
endinterface

// File: rtl/serial_fa_adder.sv
// serial_fa_adder
//   Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop
//   processes WIDTH-bit operands LSB-first, one bit per clock.
//   Subtraction is A + ~B + 1 through the same cell.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_fa_adder_if.slave
//          iStart/iSub/iA/iB/iC in, oS/oC/oOvf results, oBusy (RUN), oDone (1-cycle)
module serial_fa_adder #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_fa_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_next;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] s_q;
  logic             c_q, ovf_q;

  logic sum_bit, cout, accept, last;

  function automatic logic fa_sum(input logic a, input logic b, input logic ci);
    return a ^ b ^ ci;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic ci);
    return (a & b) | (a & ci) | (b & ci);
  endfunction

  assign sum_bit = fa_sum(a_sh[0], b_sh[0], carry);
  assign cout    = fa_carry(a_sh[0], b_sh[0], carry);
  assign last    = (count == LAST_CNT);

  // The partial result fills from the MSB so that after WIDTH shifts the
  // first (LSB) sum bit has reached bit 0.
  generate
    if (WIDTH == 1) begin : g_r1
      assign r_next = sum_bit;
    end else begin : g_rn
      assign r_next = {sum_bit, r_sh[WIDTH-1:1]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a start is only honoured when no operation is running
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (bus.iStart) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand load, serial processing and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      count <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.iA;
      b_sh  <= bus.iSub ? ~bus.iB : bus.iB;
      carry <= bus.iSub ? 1'b1 : bus.iC;
      count <= '0;
    end else if (state_q == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= r_next;
      carry <= cout;
      if (last) begin
        // carry still holds the carry into the MSB on this edge
        s_q   <= r_next;
        c_q   <= cout;
        ovf_q <= carry ^ cout;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign bus.oS    = s_q;
  assign bus.oC    = c_q;
  assign bus.oOvf  = ovf_q;
  assign bus.oBusy = (state_q == RUN);
  assign bus.oDone = (state_q == DONE);

endmodule

// File: tb/tb_serial_fa_adder.sv
module tb_serial_fa_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_fa_adder_if #(.WIDTH(8)) bus8 ();
  serial_fa_adder_if #(.WIDTH(3)) bus3 ();

  serial_fa_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_fa_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int checks = 0;
  int errors = 0;

  logic [33:0] q8[$];
  logic [33:0] q3[$];

  int busy_run8 = 0;
  int busy_run3 = 0;
  int cyc = 0;
  int last_done8 = -1;
  bit hold8 = 1'b0;

  // Reference: plain integer arithmetic on the operands, returns {ovf, carry, sum}
  function automatic logic [33:0] model(input int w, input bit sub,
                                        input longint unsigned a, input longint unsigned b,
                                        input bit c);
    longint unsigned mask, full, r;
    bit co, ovf, sa, sb, sr;
    mask = (64'd1 << w) - 1;
    sa = bit'((a >> (w - 1)) & 1);
    sb = bit'((b >> (w - 1)) & 1);
    if (sub) begin
      r   = (a - b) & mask;
      co  = (a >= b);
      sr  = bit'((r >> (w - 1)) & 1);
      ovf = (sa != sb) && (sr != sa);
    end else begin
      full = a + b + longint'(c);
      r    = full & mask;
      co   = bit'((full >> w) & 1);
      sr   = bit'((r >> (w - 1)) & 1);
      ovf  = (sa == sb) && (sr != sa);
    end
    return {ovf, co, r[31:0]};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Wait until the 8-bit adder can accept, then present one start for one edge
  task automatic start8(input bit sub, input logic [7:0] a, input logic [7:0] b, input bit c);
    int n;
    n = 0;
    @(negedge clk);
    while (bus8.oBusy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus8.oBusy) timeout_fail("start8_wait");
    bus8.iStart = 1'b1;
    bus8.iSub   = sub;
    bus8.iA     = a;
    bus8.iB     = b;
    bus8.iC     = c;
    q8.push_back(model(8, sub, a, b, c));
    @(posedge clk);
    #1 bus8.iStart = 1'b0;
  endtask

  initial begin
    bus8.iStart = 1'b0; bus8.iSub = 1'b0; bus8.iA = '0; bus8.iB = '0; bus8.iC = 1'b0;
    bus3.iStart = 1'b0; bus3.iSub = 1'b0; bus3.iA = '0; bus3.iB = '0; bus3.iC = 1'b0;

    fork
      begin : driver
        int pushed, n;
        #7;
        chk("rst_oS", bus8.oS, 0);
        chk("rst_oC", bus8.oC, 0);
        chk("rst_oOvf", bus8.oOvf, 0);
        chk("rst_oBusy", bus8.oBusy, 0);
        chk("rst_oDone", bus8.oDone, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed operations
        start8(0, 8'h5A, 8'h3C, 0);
        start8(0, 8'hFF, 8'h01, 1);
        start8(0, 8'h00, 8'h00, 0);
        start8(1, 8'h10, 8'h20, 0);
        start8(1, 8'h80, 8'h01, 0);

        // Random single operations
        for (int i = 0; i < 20; i++)
          start8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

        // iStart held high, operands changing every cycle
        hold8 = 1'b1;
        pushed = 0;
        n = 0;
        bus8.iStart = 1'b1;
        while (pushed < 8 && n < 200) begin
          @(negedge clk);
          n++;
          bus8.iSub = 1'($urandom);
          bus8.iA   = 8'($urandom);
          bus8.iB   = 8'($urandom);
          bus8.iC   = 1'($urandom);
          if (!bus8.oBusy) begin
            q8.push_back(model(8, bus8.iSub, bus8.iA, bus8.iB, bus8.iC));
            pushed++;
          end
        end
        if (pushed < 8) timeout_fail("hold8_stream");
        @(posedge clk);
        #1 bus8.iStart = 1'b0;
        hold8 = 1'b0;

        // Start pulse and operand churn while running are ignored
        start8(0, 8'h33, 8'h44, 1);
        repeat (2) @(negedge clk);
        bus8.iStart = 1'b1;
        bus8.iA = 8'($urandom); bus8.iB = 8'($urandom); bus8.iSub = 1'b1; bus8.iC = 1'b0;
        @(posedge clk);
        #1 bus8.iStart = 1'b0;
        @(negedge clk);
        bus8.iA = 8'($urandom); bus8.iB = 8'($urandom);

        // Asynchronous reset during bit 4 of an operation
        start8(0, 8'h01, 8'h02, 0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        q8.delete();
        chk("arst_oS", bus8.oS, 0);
        chk("arst_oC", bus8.oC, 0);
        chk("arst_oOvf", bus8.oOvf, 0);
        chk("arst_oBusy", bus8.oBusy, 0);
        chk("arst_oDone", bus8.oDone, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("arst_no_done_q", q8.size(), 0);
        start8(0, 8'h01, 8'h01, 0);

        // Exhaustive 3-bit sweep with iStart held high
        bus3.iStart = 1'b1;
        for (int s = 0; s < 2; s++)
          for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
              for (int c = 0; c < 2; c++) begin
                n = 0;
                @(negedge clk);
                while (bus3.oBusy && n < 20) begin
                  @(negedge clk);
                  n++;
                end
                if (bus3.oBusy) timeout_fail("start3_wait");
                bus3.iSub = 1'(s);
                bus3.iA   = 3'(a);
                bus3.iB   = 3'(b);
                bus3.iC   = 1'(c);
                q3.push_back(model(3, bus3.iSub, bus3.iA, bus3.iB, bus3.iC));
                @(posedge clk);
              end
        #1 bus3.iStart = 1'b0;

        // Drain outstanding results
        n = 0;
        while ((q8.size() != 0 || q3.size() != 0) && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("drain_q8", q8.size(), 0);
        chk("drain_q3", q3.size(), 0);
        repeat (2) @(negedge clk);
      end

      begin : monitor
        logic [33:0] e;
        forever begin
          @(negedge clk);
          cyc++;
          if (rst) begin
            busy_run8 = 0;
            busy_run3 = 0;
            last_done8 = -1;
          end else begin
            if (bus8.oDone) begin
              if (q8.size() == 0) begin
                timeout_fail("done8_unexpected");
              end else begin
                e = q8.pop_front();
                chk("w8_oS", bus8.oS, e[7:0]);
                chk("w8_oC", bus8.oC, e[32]);
                chk("w8_oOvf", bus8.oOvf, e[33]);
              end
              chk("w8_busy_cycles", busy_run8, 8);
              if (hold8 && last_done8 >= 0) chk("w8_done_period", cyc - last_done8, 9);
              last_done8 = hold8 ? cyc : -1;
              busy_run8 = 0;
            end else if (bus8.oBusy) begin
              busy_run8++;
            end

            if (bus3.oDone) begin
              if (q3.size() == 0) begin
                timeout_fail("done3_unexpected");
              end else begin
                e = q3.pop_front();
                chk("w3_oS", bus3.oS, e[2:0]);
                chk("w3_oC", bus3.oC, e[32]);
                chk("w3_oOvf", bus3.oOvf, e[33]);
              end
              chk("w3_busy_cycles", busy_run3, 3);
              busy_run3 = 0;
            end else if (bus3.oBusy) begin
              busy_run3++;
            end
          end
        end
      end
    join_any
    disable fork;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
